vec_issue_unit: RTL and testbench
=================================

// Module: vec_issue_unit
// PURPOSE
//  Upstream stage of the vector sequencer. Buffers RVV instructions from the scalar core.
//  Executes vsetvli/vsetivli locally to hold vtype/vl state.
//  Decodes vector arith/load/store ops into the vs1/vs2/vd/lmul/vsew/vl/var_dec_bits bundle
//  and issues them one at a time under the sequencer's busy handshake.
// PARAMETERS
//  VLEN    256  vector register length in bits
//  ELEN    32   max element width; SEW>ELEN sets vill
//  QDEPTH  4    instruction queue entries (power of 2)
// PORTS
//  clk           in   1   clock
//  nrst          in   1   reset, asynchronous, active-high
//  instr_valid   in   1   scalar core offers instruction
//  instr_ready   out  1   queue not full; accept on valid&&ready
//  instr         in   32  raw RVV instruction
//  rs1_data      in   32  scalar rs1 value (AVL or load/store base)
//  vseq_busy     in   1   sequencer executing an op
//  vseq_start    out  1   one-cycle issue strobe; bundle valid same cycle
//  vs1,vs2,vd    out  5   register fields (vd = vs3 for stores)
//  lmul          out  3   current vlmul
//  vsew          out  3   current vsew
//  vl            out  32  current vl
//  var_dec_bits  out  16  [5:0]funct6 [8:6]funct3 [9]vm [11:10]class(00 arith,01 ld,10 st) [15:12]0
//  base_addr     out  32  rs1_data of issued load/store, else 0
//  rd_we         out  1   one-cycle pulse: write rd_data to x[rd_addr]
//  rd_addr       out  5   vsetvli rd
//  rd_data       out  32  new vl
//  vill          out  1   vtype illegal
//  illegal_instr out  1   one-cycle pulse: head dropped as illegal
// BEHAVIOUR
//  Reset: queue empty, FSM IDLE, vl=0, lmul=0, vsew=0, vill=1; all strobes and bundle outputs 0.
//  Queue: FIFO of {instr,rs1_data}; instr_ready=!full; no push-bypass; push while full ignored.
//   Push and pop in the same cycle are both honoured; count unchanged.
//  FSM IDLE: acts only when head valid and vseq_busy=0; otherwise holds.
//   vset* (opcode 1010111, funct3 111, instr[31]=0 or [31:30]=11):
//    vtype=instr[30:20]; lmul=zimm[2:0]; vsew=zimm[5:3]; pop; stay IDLE; 1-cycle latency.
//    vill=1 if lmul>=4 (fractional) or (8<<vsew)>ELEN. In that case vl=0.
//    Otherwise VLMAX=(VLEN>>(3+vsew))<<lmul.
//    AVL: vsetivli uses uimm=instr[19:15]; vsetvli uses rs1_data, or VLMAX if rs1 field==0.
//    vl=min(AVL,VLMAX). rd_we=1 if rd!=0, with rd_data=new vl.
//   Arith (1010111, funct3 000/010), load (0000111), store (0100111):
//    If vill=1, drop and pulse illegal_instr.
//    If vl==0, pop and retire silently; no vseq_start.
//    Otherwise register the bundle, assert vseq_start for 1 cycle, pop, go WAIT_BUSY.
//   Any other encoding: pop, pulse illegal_instr.
//  WAIT_BUSY: bundle held; on vseq_busy=1 go WAIT_DONE.
//  WAIT_DONE: bundle held; on vseq_busy=0 go IDLE. Next issue no earlier than the following cycle.
//  vtype/vl never change while an op is in flight; vset* waits in the queue.
//  Async reset mid-operation drops queue and in-flight state immediately; no strobe afterwards.
// STRUCTURE
//  vec_pkg: opcode/funct3 constants, class encoding, issue_state_e enum, vl_t typedef.
//  Sub-module vec_instr_fifo (param DEPTH, WIDTH=64): ptr wrap via extra MSB for full/empty.
//  Top holds the decode, vtype/vl regs, VLMAX calc and the 3-state FSM.
// TESTING
//  1 Reset then vadd.vv v8,v16,v24 -> illegal_instr pulse, no vseq_start (vill=1 at reset).
//  2 vsetvli x5,x6,e32,m8 with rs1_data=100 -> vl=64, rd_we, rd_addr=5, rd_data=64, vill=0.
//  3 vsetivli e8,m1 uimm=10, then vadd.vv v8,v16,v24 -> vseq_start 1 cycle later with vs1=24,vs2=16,vd=8,vl=10,
//    var_dec_bits[11:10]=00; second op waits until vseq_busy falls.
//  4 Push 5 ops with vseq_busy=1 held -> instr_ready=0 after 4; releasing busy drains in FIFO order.
//  5 vsetvli e64 -> vill=1, vl=0; following vle32 -> illegal_instr. vsetvli x0,x0 e32,m1 -> vl=VLMAX=8.
//  6 Assert nrst during WAIT_DONE -> outputs to reset values at once; queue empty; vill=1.

Source files
------------

// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pkg
// Brief    : Shared encodings and types for the vector issue unit.
// Revision : 1.0 - initial release
// ============================================================================
package vec_pkg;

  localparam logic [6:0] C_OPC_V  = 7'b1010111;
  localparam logic [6:0] C_OPC_LD = 7'b0000111;
  localparam logic [6:0] C_OPC_ST = 7'b0100111;

  localparam logic [2:0] C_F3_OPIVV = 3'b000;
  localparam logic [2:0] C_F3_OPMVV = 3'b010;
  localparam logic [2:0] C_F3_CFG   = 3'b111;

  localparam logic [1:0] C_CLS_ARITH = 2'b00;
  localparam logic [1:0] C_CLS_LD    = 2'b01;
  localparam logic [1:0] C_CLS_ST    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } issue_state_e;

  typedef logic [31:0] vl_t;

endpackage
`default_nettype wire

// File: rtl/vec_instr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vec_instr_fifo
// Brief    : Instruction FIFO; pointers carry an extra wrap bit for full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module vec_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int C_AW = $clog2(DEPTH);

  logic [C_AW:0]      r_wptr;
  logic [C_AW:0]      r_rptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                 (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
  assign rdata = r_mem[r_rptr[C_AW-1:0]];

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push && !full)
        r_wptr <= r_wptr + (C_AW+1)'(1);
      if (pop && !empty)
        r_rptr <= r_rptr + (C_AW+1)'(1);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full)
      r_mem[r_wptr[C_AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/vec_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : vec_issue_unit
// Brief    : Buffers RVV instructions, executes vset* locally, issues ops.
// Revision : 1.0 - initial release
// ============================================================================
module vec_issue_unit
  import vec_pkg::*;
#(
  parameter int VLEN   = 256,
  parameter int ELEN   = 32,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic        vseq_busy,
  output logic        vseq_start,
  output logic [4:0]  vs1,
  output logic [4:0]  vs2,
  output logic [4:0]  vd,
  output logic [2:0]  lmul,
  output logic [2:0]  vsew,
  output vl_t         vl,
  output logic [15:0] var_dec_bits,
  output logic [31:0] base_addr,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        vill,
  output logic        illegal_instr
);

  issue_state_e r_state;
  logic [31:0]  w_hi;
  logic [31:0]  w_hrs1;
  logic         w_full;
  logic         w_empty;
  logic         w_fire;

  assign w_fire      = (r_state == ST_IDLE) && !w_empty && !vseq_busy;
  assign instr_ready = !w_full;

  vec_instr_fifo #(.DEPTH(QDEPTH), .WIDTH(64)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (instr_valid),
    .wdata ({instr, rs1_data}),
    .pop   (w_fire),
    .rdata ({w_hi, w_hrs1}),
    .full  (w_full),
    .empty (w_empty)
  );

  logic       w_is_vset, w_is_arith, w_is_ld, w_is_st;
  logic [2:0] w_zlmul, w_zsew;
  logic       w_vill_new;
  vl_t        w_vlmax, w_avl, w_vl_new;
  logic [1:0] w_cls;

  assign w_is_vset  = (w_hi[6:0] == C_OPC_V) && (w_hi[14:12] == C_F3_CFG) &&
                      (!w_hi[31] || (w_hi[31:30] == 2'b11));
  assign w_is_arith = (w_hi[6:0] == C_OPC_V) &&
                      ((w_hi[14:12] == C_F3_OPIVV) || (w_hi[14:12] == C_F3_OPMVV));
  assign w_is_ld    = (w_hi[6:0] == C_OPC_LD);
  assign w_is_st    = (w_hi[6:0] == C_OPC_ST);

  assign w_zlmul    = w_hi[22:20];
  assign w_zsew     = w_hi[25:23];
  // Fractional LMUL is not supported and is treated as an illegal vtype.
  assign w_vill_new = w_zlmul[2] || ((32'd8 << w_zsew) > 32'(ELEN));
  assign w_vlmax    = (32'(VLEN) >> (3 + w_zsew)) << w_zlmul;
  assign w_avl      = w_hi[31] ? 32'(w_hi[19:15]) :
                      ((w_hi[19:15] == 5'd0) ? w_vlmax : w_hrs1);
  assign w_vl_new   = w_vill_new ? '0 : ((w_avl < w_vlmax) ? w_avl : w_vlmax);
  assign w_cls      = w_is_ld ? C_CLS_LD : (w_is_st ? C_CLS_ST : C_CLS_ARITH);

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state       <= ST_IDLE;
      vseq_start    <= 1'b0;
      vs1           <= '0;
      vs2           <= '0;
      vd            <= '0;
      lmul          <= '0;
      vsew          <= '0;
      vl            <= '0;
      var_dec_bits  <= '0;
      base_addr     <= '0;
      rd_we         <= 1'b0;
      rd_addr       <= '0;
      rd_data       <= '0;
      vill          <= 1'b1;
      illegal_instr <= 1'b0;
    end else begin
      vseq_start    <= 1'b0;
      rd_we         <= 1'b0;
      illegal_instr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            if (w_is_vset) begin
              lmul    <= w_zlmul;
              vsew    <= w_zsew;
              vl      <= w_vl_new;
              vill    <= w_vill_new;
              rd_we   <= (w_hi[11:7] != 5'd0);
              rd_addr <= w_hi[11:7];
              rd_data <= w_vl_new;
            end else if (w_is_arith || w_is_ld || w_is_st) begin
              if (vill) begin
                illegal_instr <= 1'b1;
              end else if (vl != '0) begin
                vs1          <= w_hi[19:15];
                vs2          <= w_hi[24:20];
                vd           <= w_hi[11:7];
                var_dec_bits <= {4'b0000, w_cls, w_hi[25], w_hi[14:12], w_hi[31:26]};
                base_addr    <= (w_is_ld || w_is_st) ? w_hrs1 : '0;
                vseq_start   <= 1'b1;
                r_state      <= ST_WAIT_BUSY;
              end
            end else begin
              illegal_instr <= 1'b1;
            end
          end
        end
        ST_WAIT_BUSY: if (vseq_busy)  r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!vseq_busy) r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_issue_unit
// Brief    : Directed self-checking bench for vec_issue_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_issue_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic        vseq_busy;
  logic        vseq_start;
  logic [4:0]  vs1, vs2, vd;
  logic [2:0]  lmul, vsew;
  logic [31:0] vl;
  logic [15:0] var_dec_bits;
  logic [31:0] base_addr;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        vill;
  logic        illegal_instr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vec_issue_unit #(.VLEN(256), .ELEN(32), .QDEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_data(rs1_data), .vseq_busy(vseq_busy), .vseq_start(vseq_start),
    .vs1(vs1), .vs2(vs2), .vd(vd), .lmul(lmul), .vsew(vsew), .vl(vl),
    .var_dec_bits(var_dec_bits), .base_addr(base_addr), .rd_we(rd_we),
    .rd_addr(rd_addr), .rd_data(rd_data), .vill(vill), .illegal_instr(illegal_instr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] rs1);
    int n = 0;
    instr = ins; rs1_data = rs1; instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin tick(); n++; end
    if (!instr_ready) check("push_timeout", 32'd0, 32'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [4:0] vd_exp);
    int n = 0;
    while (!vseq_start && n < 8) begin tick(); n++; end
    check({tag, "_start"}, {31'd0, vseq_start}, 32'd1);
    check({tag, "_vd"}, {27'd0, vd}, {27'd0, vd_exp});
  endtask

  // Sequencer model: busy for one cycle after each issue.
  task automatic seq_ack();
    vseq_busy = 1'b1; tick();
    vseq_busy = 1'b0; tick();
  endtask

  function automatic logic [31:0] vv(input logic [4:0] d, input logic [4:0] s2, input logic [4:0] s1);
    return {6'b0, 1'b1, s2, s1, 3'b000, d, 7'b1010111};
  endfunction
  function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs, input logic [10:0] z);
    return {1'b0, z, rs, 3'b111, rd, 7'b1010111};
  endfunction
  function automatic logic [31:0] vsetivli(input logic [4:0] rd, input logic [4:0] u, input logic [9:0] z);
    return {2'b11, z, u, 3'b111, rd, 7'b1010111};
  endfunction
  function automatic logic [31:0] vle32(input logic [4:0] d, input logic [4:0] rs);
    return {6'b0, 1'b1, 5'd0, rs, 3'b110, d, 7'b0000111};
  endfunction
  function automatic logic [31:0] vse32(input logic [4:0] s3, input logic [4:0] rs);
    return {6'b0, 1'b1, 5'd0, rs, 3'b110, s3, 7'b0100111};
  endfunction

  initial begin
    int starts;
    nrst = 1'b1; instr_valid = 1'b0; instr = '0; rs1_data = '0; vseq_busy = 1'b0;
    repeat (2) tick();
    nrst = 1'b0;
    tick();
    check("rst_vl", vl, 32'd0);
    check("rst_vill", {31'd0, vill}, 32'd1);
    check("rst_lmul", {29'd0, lmul}, 32'd0);
    check("rst_vsew", {29'd0, vsew}, 32'd0);
    check("rst_start", {31'd0, vseq_start}, 32'd0);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_dec", {16'd0, var_dec_bits}, 32'd0);

    // Op while vill=1 after reset is dropped as illegal.
    push(vv(5'd8, 5'd16, 5'd24), 32'd0);
    tick();
    check("t1_illegal", {31'd0, illegal_instr}, 32'd1);
    check("t1_start", {31'd0, vseq_start}, 32'd0);
    tick();
    check("t1_pulse", {31'd0, illegal_instr}, 32'd0);

    // vsetvli x5,x6,e32,m8 with AVL=100 -> VLMAX=64.
    push(vsetvli(5'd5, 5'd6, 11'b000_0001_0011), 32'd100);
    tick();
    check("t2_rd_we", {31'd0, rd_we}, 32'd1);
    check("t2_rd_addr", {27'd0, rd_addr}, 32'd5);
    check("t2_rd_data", rd_data, 32'd64);
    check("t2_vl", vl, 32'd64);
    check("t2_vill", {31'd0, vill}, 32'd0);
    check("t2_lmul", {29'd0, lmul}, 32'd3);
    check("t2_vsew", {29'd0, vsew}, 32'd2);
    tick();
    check("t2_rd_we_pulse", {31'd0, rd_we}, 32'd0);

    // vsetivli e8,m1 uimm=10 then vadd.vv v8,v16,v24.
    push(vsetivli(5'd0, 5'd10, 10'd0), 32'd0);
    push(vv(5'd8, 5'd16, 5'd24), 32'd0);
    tick();
    check("t3_start", {31'd0, vseq_start}, 32'd1);
    check("t3_vs1", {27'd0, vs1}, 32'd24);
    check("t3_vs2", {27'd0, vs2}, 32'd16);
    check("t3_vd", {27'd0, vd}, 32'd8);
    check("t3_vl", vl, 32'd10);
    check("t3_dec", {16'd0, var_dec_bits}, 32'h0200);
    check("t3_base", base_addr, 32'd0);
    tick();
    check("t3_start_pulse", {31'd0, vseq_start}, 32'd0);
    push(vv(5'd1, 5'd2, 5'd3), 32'd0);
    vseq_busy = 1'b1;
    repeat (3) tick();
    check("t3_wait_start", {31'd0, vseq_start}, 32'd0);
    check("t3_hold_vd", {27'd0, vd}, 32'd8);
    vseq_busy = 1'b0;
    tick();
    check("t3_gap", {31'd0, vseq_start}, 32'd0);
    tick();
    check("t3_second_start", {31'd0, vseq_start}, 32'd1);
    check("t3_second_vd", {27'd0, vd}, 32'd1);
    seq_ack();

    // Fill queue while busy; fifth offer stalls until a pop.
    vseq_busy = 1'b1;
    for (int k = 11; k < 15; k++) push(vv(5'(k), 5'd2, 5'd3), 32'd0);
    check("t4_full", {31'd0, instr_ready}, 32'd0);
    instr = vv(5'd15, 5'd2, 5'd3); instr_valid = 1'b1;
    vseq_busy = 1'b0;
    tick();
    check("t4_first_start", {31'd0, vseq_start}, 32'd1);
    check("t4_first_vd", {27'd0, vd}, 32'd11);
    check("t4_ready_again", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    seq_ack();
    for (int k = 12; k < 16; k++) begin
      wait_start($sformatf("t4_op%0d", k), 5'(k));
      seq_ack();
    end

    // SEW=64 exceeds ELEN -> vill, vl=0; loads then illegal.
    push(vsetvli(5'd0, 5'd6, 11'b000_0001_1000), 32'd5);
    tick();
    check("t5_vill", {31'd0, vill}, 32'd1);
    check("t5_vl0", vl, 32'd0);
    push(vle32(5'd4, 5'd7), 32'h1000);
    tick();
    check("t5_ld_illegal", {31'd0, illegal_instr}, 32'd1);
    check("t5_ld_nostart", {31'd0, vseq_start}, 32'd0);
    push(vsetvli(5'd0, 5'd0, 11'b000_0001_0000), 32'd0);
    tick();
    check("t5_vlmax", vl, 32'd8);
    check("t5_vill_clr", {31'd0, vill}, 32'd0);
    check("t5_no_rd_we", {31'd0, rd_we}, 32'd0);
    // vl=0 retires silently.
    push(vsetivli(5'd0, 5'd0, 10'd0), 32'd0);
    tick();
    check("t5_vl_zero", vl, 32'd0);
    push(vv(5'd2, 5'd3, 5'd4), 32'd0);
    tick();
    check("t5_zero_nostart", {31'd0, vseq_start}, 32'd0);
    check("t5_zero_noillegal", {31'd0, illegal_instr}, 32'd0);
    push(vsetvli(5'd0, 5'd0, 11'b000_0001_0000), 32'd0);
    push(vse32(5'd9, 5'd10), 32'h2000);
    wait_start("t5_st", 5'd9);
    check("t5_st_base", base_addr, 32'h2000);
    check("t5_st_dec", {16'd0, var_dec_bits}, 32'h0B80);
    check("t5_st_vl", vl, 32'd8);
    seq_ack();

    // Reset during WAIT_DONE with an op still queued.
    push(vsetivli(5'd0, 5'd4, 10'd0), 32'd0);
    push(vv(5'd6, 5'd7, 5'd8), 32'd0);
    wait_start("t6", 5'd6);
    vseq_busy = 1'b1;
    tick();
    push(vv(5'd1, 5'd1, 5'd1), 32'd0);
    #2 nrst = 1'b1;
    #1;
    check("t6_vl", vl, 32'd0);
    check("t6_vill", {31'd0, vill}, 32'd1);
    check("t6_vd", {27'd0, vd}, 32'd0);
    check("t6_start", {31'd0, vseq_start}, 32'd0);
    check("t6_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    nrst = 1'b0;
    vseq_busy = 1'b0;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vseq_start || illegal_instr) starts++;
    end
    check("t6_quiet", 32'(starts), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
